bcd_modn_counter: RTL
=====================

# bcd_modn_counter

Parametrised synchronous BCD counter with programmable modulus, up/down direction, parallel load and a cascade terminal-count output. It is the general-purpose timekeeping counter for the clock datapath. One instance can form the seconds (mod 60), minutes (mod 60) or hours (mod 24 / mod 12) field, or a single mod-10 digit. Instances are chained through TC into EN to build the full time-of-day and alarm-set chains.

## Interface
- DIGITS, default 2: number of BCD digits; legal range 1..4.
- MODULUS, default 60: count modulus; the counter sequence is 0..MODULUS-1; legal range 2..10**DIGITS.
- CP  input  1  clock; all state updates on the rising edge.
- nCR  input  1  reset; synchronous, active-low; sampled on the rising edge of CP.
- EN  input  1  count enable; one step per CP edge while high.
- UP  input  1  direction; 1 = increment, 0 = decrement.
- LD  input  1  parallel load request.
- D  input  4*DIGITS  load value, packed BCD, digit 0 in D[3:0].
- Cnt  output  4*DIGITS  current count, packed BCD, registered.
- TC  output  1  terminal count; combinational; used for cascade and carry/borrow.
- ERR  output  1  invalid-load flag; registered; one-cycle pulse.

## Operation
- Priority on each CP edge: nCR low, then LD, then EN, then hold.
- nCR low: Cnt <= 0 and ERR <= 0, regardless of LD and EN.
- LD high with D valid: Cnt <= D and ERR <= 0. EN is ignored that cycle.
  - D is valid only if every digit is ≤ 9 and the BCD value is < MODULUS.
- LD high with D invalid: Cnt holds and ERR <= 1.
- EN high, LD low, UP = 1:
  - If Cnt == MODULUS-1, Cnt <= 0 (wrap).
  - Otherwise Cnt <= Cnt+1 in BCD: a digit at 9 becomes 0 and carries into the next digit.
- EN high, LD low, UP = 0:
  - If Cnt == 0, Cnt <= MODULUS-1 (wrap).
  - Otherwise Cnt <= Cnt-1 in BCD: a digit at 0 becomes 9 and borrows from the next digit.
- EN low and LD low: Cnt holds and ERR <= 0.
- TC = EN & ~LD & nCR & (UP ? Cnt == MODULUS-1 : Cnt == 0). It is high only in the cycle whose edge causes the wrap.
- UP may change on any cycle. Each step uses the UP value sampled at that edge; there is no pipeline penalty.
- Cnt never leaves the set {valid BCD, < MODULUS} after reset. Constant arithmetic is evaluated at elaboration.
- With DIGITS=1 and MODULUS=10, UP tied high and LD tied low, the behaviour is an exact mod-10 BCD counter, except that reset is synchronous.

## Timing
- Reset value: Cnt = 0, ERR = 0. TC follows its equation (it is 0 while nCR is low).
- Count and load latency: one CP edge; the new Cnt is visible after that edge.
- TC: zero latency, combinational from Cnt, EN, LD, UP and nCR. When cascading, the downstream EN = upstream TC, and both stages update on the same edge.
- ERR: asserted the cycle after the invalid load edge, for exactly one cycle unless invalid loads repeat.
- Reset mid-count or mid-load: the reset wins on that edge, and no ERR is raised.
- The value set by a load counts from the next edge. A load on the wrap cycle suppresses both the wrap and TC.

## Structure
- Shared package clock_pkg holds:
  - BCD_W = 4.
  - Function to_bcd(int) returning the packed BCD constant, used for MODULUS-1.
  - Function bcd_valid(value, modulus) for the load check.
  - Standard modulus constants MOD_SEC = 60, MOD_MIN = 60, MOD_HR24 = 24.
- Sub-module bcd_digit: one 4-bit digit.
  - Inputs: step, up, load, load data, force-zero, force-value.
  - Outputs: the digit, plus carry_out (9→0 while up) and borrow_out (0→9 while down).
  - DIGITS copies are generated and chained.
  - The top level handles the MODULUS wrap compare, load validation, ERR and TC.
- Parameter legality is checked at elaboration; an illegal DIGITS or MODULUS stops elaboration.

## Test plan
- Reset and count (DIGITS=2, MODULUS=60): nCR low for 2 edges, then EN=1, UP=1 for 61 edges.
  - Response: Cnt runs 0x00..0x59 then 0x00; TC is high only while Cnt=0x59; the 0x09→0x10 step is correct.
- Down wrap: load 0x01, then EN=1, UP=0 for 3 edges.
  - Response: Cnt 0x01→0x00→0x59→0x58; TC is high only while Cnt=0x00.
- Invalid load: LD=1 with D=0x60, then with D=0x3A, starting from Cnt=0x12.
  - Response: Cnt stays 0x12; ERR pulses high one cycle after each load.
  - Then LD=1 with D=0x45: Cnt=0x45 and ERR=0.
- Priority: at Cnt=0x59, UP=1, assert EN=1, LD=1 (D=0x30) and nCR=0 on the same edge.
  - Response: Cnt=0x00 and ERR=0.
  - Next edge, with nCR=1 and LD=1: Cnt=0x30, and TC stayed 0 throughout.
- Cascade (sec MODULUS=60 → min MODULUS=60 → hr MODULUS=24, each EN fed by the previous TC): preload 23:59:59, then one edge.
  - Response: 00:00:00; all three TCs are high in the cycle before that edge.
- Single digit (DIGITS=1, MODULUS=10): count up for 25 edges, toggling EN low every 3rd cycle.
  - Response: Cnt holds on EN=0, wraps 9→0, and the final value matches a reference model.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants and BCD helpers for the clock-datapath counters.
package clock_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 4;
    localparam int MAX_BCD_W  = BCD_W * MAX_DIGITS;

    localparam int MOD_SEC  = 60;
    localparam int MOD_MIN  = 60;
    localparam int MOD_HR24 = 24;

    // Packed BCD image of a non-negative integer; only ever called on constants.
    function automatic logic [MAX_BCD_W-1:0] to_bcd(input int value);
        logic [MAX_BCD_W-1:0] result;
        int                   remain;
        result = '0;
        remain = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            result[i*BCD_W +: BCD_W] = BCD_W'(remain % 10);
            remain = remain / 10;
        end
        return result;
    endfunction

    // True when every digit is 0..9 and the decimal value is below the modulus.
    function automatic logic bcd_valid(input logic [MAX_BCD_W-1:0] value, input int modulus);
        logic digitsOk;
        int   decimal;
        digitsOk = 1'b1;
        decimal  = 0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (value[i*BCD_W +: BCD_W] > 4'd9) begin
                digitsOk = 1'b0;
            end
            decimal = decimal * 10 + int'(value[i*BCD_W +: BCD_W]);
        end
        return digitsOk && (decimal < modulus);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter; ripple carry/borrow outputs feed the next digit's step.
module bcd_digit
    import clock_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_step,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_loadD,
    input  logic             i_forceZero,
    input  logic             i_forceVal,
    input  logic [BCD_W-1:0] i_forceD,
    output logic [BCD_W-1:0] o_digit,
    output logic             o_carry,
    output logic             o_borrow
);

    logic [BCD_W-1:0] r_digit;

    // Force-zero doubles as the synchronous reset path, so it outranks everything.
    always_ff @(posedge i_clk) begin
        if (i_forceZero) begin
            r_digit <= '0;
        end else if (i_forceVal) begin
            r_digit <= i_forceD;
        end else if (i_load) begin
            r_digit <= i_loadD;
        end else if (i_step) begin
            if (i_up) begin
                r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
            end else begin
                r_digit <= (r_digit == 4'd0) ? 4'd9 : r_digit - 4'd1;
            end
        end
    end

    assign o_digit  = r_digit;
    assign o_carry  = i_step &  i_up & (r_digit == 4'd9);
    assign o_borrow = i_step & ~i_up & (r_digit == 4'd0);

endmodule

// File: rtl/bcd_modn_counter.sv
// Programmable-modulus BCD up/down counter with parallel load, cascade TC and invalid-load ERR.
module bcd_modn_counter
    import clock_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input  logic                    CP,
    input  logic                    nCR,
    input  logic                    EN,
    input  logic                    UP,
    input  logic                    LD,
    input  logic [BCD_W*DIGITS-1:0] D,
    output logic [BCD_W*DIGITS-1:0] Cnt,
    output logic                    TC,
    output logic                    ERR
);

    localparam int                   W       = BCD_W * DIGITS;
    localparam logic [MAX_BCD_W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_badDigits
        $error("bcd_modn_counter: DIGITS must be 1..4");
    end
    if (MODULUS < 2 || MODULUS > 10**DIGITS) begin : g_badModulus
        $error("bcd_modn_counter: MODULUS must be 2..10**DIGITS");
    end

    logic [MAX_BCD_W-1:0] w_dExt;
    logic                 w_loadOk;
    logic                 w_atMax;
    logic                 w_countEn;
    logic                 w_forceZero;
    logic                 w_forceVal;
    logic                 w_load;
    logic [DIGITS:0]      w_step;
    logic                 r_err;

    always_comb begin
        w_dExt        = '0;
        w_dExt[W-1:0] = D;
    end

    assign w_loadOk  = bcd_valid(w_dExt, MODULUS);
    assign w_atMax   = (Cnt == MAX_BCD[W-1:0]);
    assign w_countEn = nCR & ~LD & EN;

    // A borrow rippling out of the top digit means every digit was zero, i.e. the down-wrap point.
    assign TC = UP ? (w_countEn & w_atMax) : w_step[DIGITS];

    assign w_forceZero = ~nCR | (TC & UP);
    assign w_forceVal  = TC & ~UP;
    assign w_load      = nCR & LD & w_loadOk;
    assign w_step[0]   = w_countEn;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic w_carry;
        logic w_borrow;

        bcd_digit u_digit (
            .i_clk       (CP),
            .i_step      (w_step[g]),
            .i_up        (UP),
            .i_load      (w_load),
            .i_loadD     (D[g*BCD_W +: BCD_W]),
            .i_forceZero (w_forceZero),
            .i_forceVal  (w_forceVal),
            .i_forceD    (MAX_BCD[g*BCD_W +: BCD_W]),
            .o_digit     (Cnt[g*BCD_W +: BCD_W]),
            .o_carry     (w_carry),
            .o_borrow    (w_borrow)
        );

        assign w_step[g+1] = w_carry | w_borrow;
    end

    always_ff @(posedge CP) begin
        if (!nCR) begin
            r_err <= 1'b0;
        end else begin
            r_err <= LD & ~w_loadOk;
        end
    end

    assign ERR = r_err;

endmodule
